// File: rtl/rate_sched_pkg.sv
// Shared constants and state encoding for the rate scheduler.
package rate_sched_pkg;

    localparam int unsigned CNT_W     = 32;
    localparam int unsigned TC0_DEF   = 99_999_999;
    localparam int unsigned TC1_DEF   = 49_999_999;
    localparam int unsigned TC2_DEF   = 24_999_999;
    localparam int unsigned TC3_DEF   = 12_499_999;
    localparam int unsigned PX_TC_DEF = 3;

    typedef enum logic {
        PAUSED = 1'b0,
        RUN    = 1'b1
    } state_t;

endpackage

// File: rtl/strobe_div.sv
// Free-running divider: one-cycle registered strobe every TC+1 cycles.
module strobe_div #(
    parameter int unsigned TC = 3
) (
    input  logic clk_in,
    input  logic rst_n,
    output logic en
);

    localparam int unsigned W = ($clog2(TC + 1) < 2) ? 2 : $clog2(TC + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            en  <= 1'b0;
        end else if (cnt == W'(TC)) begin
            cnt <= '0;
            en  <= 1'b1;
        end else begin
            cnt <= cnt + W'(1);
            en  <= 1'b0;
        end
    end

endmodule

// File: rtl/rate_sched.sv
// Tick scheduler with pause/step control and deferred rate switching.
module rate_sched
    import rate_sched_pkg::*;
#(
    parameter int unsigned TC0   = TC0_DEF,
    parameter int unsigned TC1   = TC1_DEF,
    parameter int unsigned TC2   = TC2_DEF,
    parameter int unsigned TC3   = TC3_DEF,
    parameter int unsigned PX_TC = PX_TC_DEF
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       run,
    input  logic       step,
    input  logic       rate_req,
    input  logic [1:0] rate_sel,
    output logic       tick,
    output logic       px_en,
    output logic       rate_ack,
    output logic       busy,
    output logic [1:0] cur_rate
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT_W-1:0]   tc_cur;
    logic               tick_nxt, ack_nxt, busy_nxt;
    logic [1:0]         cur_nxt, pend_rate, pend_nxt;

    strobe_div #(.TC(PX_TC)) u_px_div (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .en     (px_en)
    );

    always_comb begin
        case (cur_rate)
            2'd0:    tc_cur = CNT_W'(TC0);
            2'd1:    tc_cur = CNT_W'(TC1);
            2'd2:    tc_cur = CNT_W'(TC2);
            default: tc_cur = CNT_W'(TC3);
        endcase
    end

    // Next-state and registered-output logic; a pending rate waits for a wrap
    // while running, but is taken immediately (with a count restart) while paused.
    always_comb begin
        state_nxt = run ? RUN : PAUSED;
        cnt_nxt   = cnt;
        tick_nxt  = 1'b0;
        ack_nxt   = 1'b0;
        busy_nxt  = busy;
        cur_nxt   = cur_rate;
        pend_nxt  = pend_rate;

        if (state == RUN) begin
            if (cnt == tc_cur) begin
                cnt_nxt  = '0;
                tick_nxt = 1'b1;
                if (busy) begin
                    cur_nxt  = pend_rate;
                    busy_nxt = 1'b0;
                    ack_nxt  = 1'b1;
                end
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else begin
            if (step && !run) begin
                cnt_nxt  = '0;
                tick_nxt = 1'b1;
            end
            if (busy) begin
                cnt_nxt  = '0;
                cur_nxt  = pend_rate;
                busy_nxt = 1'b0;
                ack_nxt  = 1'b1;
            end
        end

        // A request coinciding with an application becomes the next pending one.
        if (rate_req) begin
            pend_nxt = rate_sel;
            busy_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PAUSED;
            cnt       <= '0;
            tick      <= 1'b0;
            rate_ack  <= 1'b0;
            busy      <= 1'b0;
            cur_rate  <= 2'd0;
            pend_rate <= 2'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tick      <= tick_nxt;
            rate_ack  <= ack_nxt;
            busy      <= busy_nxt;
            cur_rate  <= cur_nxt;
            pend_rate <= pend_nxt;
        end
    end

endmodule

// File: doc/rate_sched.md
RATE_SCHED -- requirements
Module: rate_sched

Interface
REQ-001 Parameter TC0, default 99_999_999, rate-0 terminal count (tick period TC0+1 cycles, 1 Hz at 100 MHz).
REQ-002 Parameter TC1, default 49_999_999, rate-1 terminal count (2 Hz).
REQ-003 Parameter TC2, default 24_999_999, rate-2 terminal count (4 Hz).
REQ-004 Parameter TC3, default 12_499_999, rate-3 terminal count (8 Hz).
REQ-005 Parameter PX_TC, default 3, pixel-enable terminal count (divide-by-4).
REQ-006 clk_in  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 run  input  1  level; 1 = tick counter advances, 0 = paused.
REQ-009 step  input  1  one-cycle pulse; single tick request while paused.
REQ-010 rate_req  input  1  one-cycle pulse; request rate change to rate_sel.
REQ-011 rate_sel  input  2  requested rate index, sampled only when rate_req=1.
REQ-012 tick  output  1  registered one-cycle game/update strobe.
REQ-013 px_en  output  1  registered one-cycle enable every PX_TC+1 cycles.
REQ-014 rate_ack  output  1  one-cycle pulse in the cycle a pending rate is applied.
REQ-015 busy  output  1  1 while a rate change is pending.
REQ-016 cur_rate  output  2  rate index currently in effect.

Function
REQ-017 Two states SHALL exist: PAUSED and RUN; PAUSED->RUN when run=1, RUN->PAUSED when run=0, evaluated every cycle.
REQ-018 32-bit counter cnt SHALL increment in RUN only; in PAUSED it SHALL hold its value.
REQ-019 In RUN, when cnt equals TC[cur_rate], cnt SHALL wrap to 0 and tick SHALL be 1 in the following cycle (exactly one cycle).
REQ-020 From cnt=0, first tick SHALL occur TC[cur_rate]+1 cycles after entering RUN; resume after pause SHALL continue from the held cnt.
REQ-021 step in PAUSED SHALL clear cnt to 0 and assert tick the next cycle; step in RUN, or in the cycle run rises, SHALL be ignored.
REQ-022 rate_req SHALL latch rate_sel into pend_rate and set busy the next cycle; a further rate_req while pending SHALL overwrite pend_rate (last wins, one ack).
REQ-023 In RUN, a pending rate SHALL be applied at the first wrap occurring strictly after the request cycle: cur_rate<=pend_rate, busy<=0, rate_ack=1 concurrently with that wrap's tick.
REQ-024 In PAUSED, a pending rate SHALL be applied the cycle after busy rises, with cnt cleared to 0 and rate_ack=1.
REQ-025 A rate_req in the same cycle as an application SHALL become a new pending request.
REQ-026 run falling while busy=1 SHALL apply the pending rate per REQ-024.
REQ-027 px_en SHALL run from a free 2-bit-or-wider counter independent of run, step and rate; asserted when its count equals PX_TC, then wraps.
REQ-028 Comparison of cnt against TC SHALL use equality; cnt never exceeds the largest TC.

Reset
REQ-029 rst_n=0 SHALL immediately force: state PAUSED, cnt 0, px counter 0, tick 0, px_en 0, rate_ack 0, busy 0, cur_rate 0, pend_rate 0.
REQ-030 Reset asserted mid-period or with a pending request SHALL discard the request; no ack is ever issued for it.
REQ-031 After rst_n rises, first px_en SHALL occur PX_TC+1 cycles later.

Structure
REQ-032 Shared package rate_sched_pkg SHALL hold default TC0..TC3, PX_TC and state encoding (PAUSED=0, RUN=1).
REQ-033 px_en SHALL come from one sub-module strobe_div (parameter TC, ports clk_in, rst_n, en output).
REQ-034 Tick counter, FSM and rate-change logic SHALL reside in rate_sched.

Verification (sim overrides TC0=7, TC1=5, TC2=3, TC3=1, PX_TC=3)
REQ-035 Reset release, run=1 -> tick at cycles 8,16,24 after run; px_en at cycles 4,8,12 after reset release.
REQ-036 run=1, rate_req with rate_sel=2 at cnt=3 -> rate_ack with the tick 5 cycles later; subsequent ticks every 4 cycles; cur_rate=2.
REQ-037 run=0 at cnt=5, hold 10 cycles, run=1 -> no tick while paused; next tick 3 cycles after resume.
REQ-038 Paused, step pulse -> tick exactly 1 cycle later, cnt=0; step while run=1 -> no extra tick.
REQ-039 Two rate_req (sel=1 then sel=3) before a wrap -> single rate_ack, cur_rate=3, tick period 2.
REQ-040 rst_n pulsed low with busy=1 -> all outputs 0 immediately, cur_rate=0, no rate_ack after release.
